// File: rtl/row_conv_ctrl.sv
// Row sequencer for the 3-PE row-stationary 1-D convolution slice: loads weights,
// streams one input row through the PE chain and writes valid results to the output FIFO.
module row_conv_ctrl #(
    parameter int KERNEL_SIZE = 3,
    parameter int LEN_W       = 8,
    parameter int FREE_W      = 4,
    parameter int PIPE_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              wgt_valid,
    input  logic              ifm_valid,
    input  logic [FREE_W-1:0] fifo_free,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ifm_ready,
    output logic              set_wgt,
    output logic              set_ifm,
    output logic              pe_set_reg,
    output logic              wr_en,
    output logic [LEN_W-1:0]  out_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WGT,
        WAIT_SPACE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int CMP_W   = (LEN_W > FREE_W) ? LEN_W : FREE_W;

    localparam logic [LEN_W-1:0]   K_LEN      = LEN_W'(KERNEL_SIZE);
    localparam logic [LEN_W-1:0]   K_LAST     = LEN_W'(KERNEL_SIZE - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

    state_t              state;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    in_cnt;
    logic [LEN_W-1:0]    n_out;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [PIPE_LAT-1:0] vpipe;
    logic                space_ok;
    logic                tag;

    assign n_out    = len - K_LEN + LEN_W'(1);
    // Both sides widened so a result count larger than the FIFO field can never pass.
    assign space_ok = CMP_W'(fifo_free) >= CMP_W'(n_out);

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign ifm_ready  = (state == STREAM);
    assign set_ifm    = ifm_ready & ifm_valid;
    assign set_wgt    = (state == LOAD_WGT) & wgt_valid;
    assign pe_set_reg = (state == STREAM) | (state == DRAIN);
    assign tag        = set_ifm & (in_cnt >= K_LAST);
    assign wr_en      = vpipe[PIPE_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            in_cnt    <= '0;
            drain_cnt <= '0;
            vpipe     <= '0;
            err       <= 1'b0;
            out_cnt   <= '0;
        end else begin
            vpipe <= (vpipe << 1) | PIPE_LAT'(tag);
            if (wr_en) begin
                out_cnt <= out_cnt + LEN_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len       <= cfg_len;
                        in_cnt    <= '0;
                        drain_cnt <= '0;
                        out_cnt   <= '0;
                        err       <= (cfg_len < K_LEN);
                        state     <= (cfg_len < K_LEN) ? DONE : LOAD_WGT;
                    end
                end
                LOAD_WGT: begin
                    if (wgt_valid) begin
                        state <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    if (space_ok) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (ifm_valid) begin
                        in_cnt <= in_cnt + LEN_W'(1);
                        if (in_cnt == len - LEN_W'(1)) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end else begin
                        // The PE chain cannot stall, so a gap poisons every in-flight psum.
                        err   <= 1'b1;
                        vpipe <= '0;
                        state <= DONE;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
